// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared widths, pixel/gradient types and pipeline sideband for the conv datapath
package conv_pkg;

    localparam int DEF_GRAD_W = 11;
    localparam int DEF_BYTE   = 8;

    typedef logic signed [DEF_GRAD_W-1:0] grad_t;
    typedef logic [DEF_BYTE-1:0]          pix_t;

    localparam pix_t PIX_MAX = '1;

    // Travels alongside each pixel so the output stage never looks back at the counters
    typedef struct packed {
        logic border;
        logic sof;
        logic eol;
        logic thr_en;
        pix_t thr;
    } side_t;

endpackage

// File: rtl/raster_pos_counter.sv
// rtl/raster_pos_counter.sv - raster x/y position tracker with border and frame/line markers
module raster_pos_counter #(
    parameter int IMG_W = 2048,
    parameter int IMG_H = 2048,
    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1,
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
    input  logic clk,
    input  logic reset,
    input  logic adv,
    output logic border,
    output logic sof,
    output logic eol
);

    logic [XW-1:0] x;
    logic [YW-1:0] y;

    logic x_last;
    logic y_last;

    assign x_last = (x == XW'(IMG_W - 1));
    assign y_last = (y == YW'(IMG_H - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            x <= '0;
            y <= '0;
        end else if (adv) begin
            if (x_last) begin
                x <= '0;
                y <= y_last ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    assign border = (x == '0) || x_last || (y == '0) || y_last;
    assign sof    = (x == '0) && (y == '0);
    assign eol    = x_last;

endmodule

// File: rtl/sobel_magnitude.sv
// rtl/sobel_magnitude.sv - Sobel gradient pair to 8-bit edge pixel, 3-stage pipeline with backpressure
module sobel_magnitude
    import conv_pkg::*;
#(
    parameter int IMG_W     = 2048,
    parameter int IMG_H     = 2048,
    parameter int BYTE      = DEF_BYTE,
    parameter int GRAD_W    = DEF_GRAD_W,
    parameter int MAG_SHIFT = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [GRAD_W-1:0] gx_in,
    input  logic signed [GRAD_W-1:0] gy_in,
    input  logic                     threshold_en,
    input  logic [BYTE-1:0]          threshold,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BYTE-1:0]          output_pixel,
    output logic                     out_sof,
    output logic                     out_eol
);

    localparam logic [GRAD_W:0] SAT = (GRAD_W + 1)'(2 ** BYTE - 1);

    logic stall;
    logic accept;
    logic pos_border, pos_sof, pos_eol;

    logic              v1;
    logic [GRAD_W-1:0] abs_x, abs_y;
    side_t             sb1;

    logic              v2;
    logic [BYTE-1:0]   mag;
    side_t             sb2;

    logic [GRAD_W-1:0] abs_gx_d, abs_gy_d;
    logic [GRAD_W:0]   sum_d, scaled_d;
    logic [BYTE-1:0]   mag_d;
    logic [BYTE-1:0]   pix_d;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;
    assign accept   = in_valid && in_ready;

    raster_pos_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_pos (
        .clk    (clk),
        .reset  (reset),
        .adv    (accept),
        .border (pos_border),
        .sof    (pos_sof),
        .eol    (pos_eol)
    );

    // Negating the most negative code wraps to 2^(GRAD_W-1), which reads correctly as unsigned
    always_comb begin
        abs_gx_d = gx_in[GRAD_W-1] ? GRAD_W'(-gx_in) : GRAD_W'(gx_in);
        abs_gy_d = gy_in[GRAD_W-1] ? GRAD_W'(-gy_in) : GRAD_W'(gy_in);
    end

    always_comb begin
        sum_d    = {1'b0, abs_x} + {1'b0, abs_y};
        scaled_d = sum_d >> MAG_SHIFT;
        mag_d    = (scaled_d > SAT) ? BYTE'(PIX_MAX) : scaled_d[BYTE-1:0];
    end

    always_comb begin
        pix_d = '0;
        if (sb2.border) begin
            pix_d = '0;
        end else if (sb2.thr_en) begin
            pix_d = (mag >= sb2.thr) ? BYTE'(PIX_MAX) : '0;
        end else begin
            pix_d = mag;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1           <= 1'b0;
            abs_x        <= '0;
            abs_y        <= '0;
            sb1          <= '0;
            v2           <= 1'b0;
            mag          <= '0;
            sb2          <= '0;
            out_valid    <= 1'b0;
            output_pixel <= '0;
            out_sof      <= 1'b0;
            out_eol      <= 1'b0;
        end else if (!stall) begin
            v1         <= accept;
            abs_x      <= abs_gx_d;
            abs_y      <= abs_gy_d;
            sb1.border <= pos_border;
            sb1.sof    <= pos_sof;
            sb1.eol    <= pos_eol;
            sb1.thr_en <= threshold_en;
            sb1.thr    <= threshold;

            v2  <= v1;
            mag <= mag_d;
            sb2 <= sb1;

            out_valid    <= v2;
            output_pixel <= pix_d;
            out_sof      <= v2 && sb2.sof;
            out_eol      <= v2 && sb2.eol;
        end
    end

endmodule

// File: tb/tb_sobel_magnitude.sv
// tb/tb_sobel_magnitude.sv - randomized self-checking bench for sobel_magnitude against a queue-based model
module tb_sobel_magnitude;

    localparam int W = 4;
    localparam int H = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready, in_ready2;
    logic signed [10:0] gx, gy;
    logic              thr_en;
    logic [7:0]        thr;
    logic              out_valid, out_valid2;
    logic              out_ready;
    logic [7:0]        pix, pix2;
    logic              sof, sof2, eol, eol2;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int idx      = 0;
    bit lat_chk  = 0;
    bit rdy_mode = 0;
    bit rdy_val  = 1;

    int q_pix[$], q_pix2[$], q_sof[$], q_eol[$], q_cyc[$];
    int log_pix[$], log_pix2[$], log_sof[$], log_eol[$];

    always #5 clk = ~clk;

    sobel_magnitude #(.IMG_W(W), .IMG_H(H), .MAG_SHIFT(0)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .gx_in(gx), .gy_in(gy), .threshold_en(thr_en), .threshold(thr),
        .out_valid(out_valid), .out_ready(out_ready), .output_pixel(pix),
        .out_sof(sof), .out_eol(eol)
    );

    sobel_magnitude #(.IMG_W(W), .IMG_H(H), .MAG_SHIFT(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .gx_in(gx), .gy_in(gy), .threshold_en(thr_en), .threshold(thr),
        .out_valid(out_valid2), .out_ready(out_ready), .output_pixel(pix2),
        .out_sof(sof2), .out_eol(eol2)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int model_pix(input int gxv, input int gyv, input int n,
                                     input bit en, input int t, input int sh);
        int x = n % W;
        int y = (n / W) % H;
        int m = ((gxv < 0 ? -gxv : gxv) + (gyv < 0 ? -gyv : gyv)) >> sh;
        if (m > 255) m = 255;
        if (x == 0 || x == W - 1 || y == 0 || y == H - 1) return 0;
        if (en) return (m >= t) ? 255 : 0;
        return m;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            q_pix.delete(); q_pix2.delete(); q_sof.delete(); q_eol.delete(); q_cyc.delete();
            idx = 0;
        end else begin
            if (out_valid && out_ready) begin
                log_pix.push_back(pix); log_pix2.push_back(pix2);
                log_sof.push_back(sof); log_eol.push_back(eol);
                if (q_pix.size() == 0) begin
                    check_eq("extra_out", 1, 0);
                end else begin
                    check_eq("pix", pix, q_pix.pop_front());
                    check_eq("pix_shift2", pix2, q_pix2.pop_front());
                    check_eq("sof", sof, q_sof[0]);
                    check_eq("sof2", sof2, q_sof.pop_front());
                    check_eq("eol", eol, q_eol[0]);
                    check_eq("eol2", eol2, q_eol.pop_front());
                    check_eq("valid2", out_valid2, 1);
                    if (lat_chk) check_eq("latency", cyc - q_cyc[0], 3);
                    void'(q_cyc.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                check_eq("ready2", in_ready2, 1);
                q_pix.push_back(model_pix(int'(gx), int'(gy), idx, thr_en, thr, 0));
                q_pix2.push_back(model_pix(int'(gx), int'(gy), idx, thr_en, thr, 2));
                q_sof.push_back((idx % (W * H)) == 0);
                q_eol.push_back((idx % W) == W - 1);
                q_cyc.push_back(cyc);
                idx++;
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rdy_mode ? ($urandom_range(0, 3) != 0) : rdy_val;
        end
    end

    task automatic send(input int gxv, input int gyv, input bit en, input int t);
        int n = 0;
        in_valid = 1'b1;
        gx       = gxv[10:0];
        gy       = gyv[10:0];
        thr_en   = en;
        thr      = t[7:0];
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check_eq("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_rand();
        send(int'($urandom_range(0, 2047)) - 1024, int'($urandom_range(0, 2047)) - 1024,
             1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
    endtask

    task automatic drain();
        int n = 0;
        while (q_pix.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_eq("drain", q_pix.size(), 0);
    endtask

    initial begin
        int held;
        int mark;
        reset = 1'b1; in_valid = 1'b0; gx = '0; gy = '0; thr_en = 1'b0; thr = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_pixel", pix, 0);
        check_eq("rst_sof", sof, 0);
        check_eq("rst_eol", eol, 0);
        check_eq("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Directed frames, back-to-back, out_ready held high
        lat_chk = 1;
        for (int i = 0; i < W * H; i++) begin
            case (i)
                5:  send(100, -50, 0, 0);
                6:  send(1020, 1020, 0, 0);
                9:  send(-1024, 0, 0, 0);
                10: send(0, 0, 0, 0);
                default: send_rand();
            endcase
        end
        for (int i = 0; i < 2 * W * H; i++) send(60, 60, 0, 0);
        for (int i = 0; i < W * H; i++) begin
            case (i)
                5:  send(100, 27, 1, 128);
                6:  send(64, -64, 1, 128);
                9:  send(150, 50, 1, 128);
                10: send(150, 50, 0, 128);
                default: send_rand();
            endcase
        end
        for (int i = 0; i < W * H; i++) begin
            if (i == 5) send(300, 200, 0, 0);
            else send_rand();
        end
        drain();
        lat_chk = 0;

        check_eq("log_size", log_pix.size(), 80);
        check_eq("f1_150", log_pix[5], 150);
        check_eq("f1_sat", log_pix[6], 255);
        check_eq("f1_negmax", log_pix[9], 255);
        check_eq("f1_zero", log_pix[10], 0);
        check_eq("f2_sof", log_sof[16], 1);
        check_eq("f2_border", log_pix[16], 0);
        check_eq("f2_int", log_pix[21], 120);
        check_eq("f3_int", log_pix[42], 120);
        check_eq("f3_eol", log_eol[35], 1);
        check_eq("thr_127", log_pix[53], 0);
        check_eq("thr_128", log_pix[54], 255);
        check_eq("thr_200", log_pix[57], 255);
        check_eq("thr_off", log_pix[58], 200);
        check_eq("shift0_sat", log_pix[69], 255);
        check_eq("shift2_125", log_pix2[69], 125);

        // Backpressure: 5 stalled cycles with in_valid held high
        fork
            begin
                for (int i = 0; i < 24; i++) send_rand();
            end
            begin
                repeat (6) @(negedge clk);
                rdy_val = 1'b0;
                @(negedge clk);
                held = pix;
                for (int k = 0; k < 5; k++) begin
                    check_eq("stall_in_ready", in_ready, 0);
                    check_eq("stall_valid", out_valid, 1);
                    check_eq("stall_pixel", pix, held);
                    if (k < 4) @(negedge clk);
                end
                rdy_val = 1'b1;
            end
        join
        drain();

        // Random bubbles and random backpressure over three frames
        rdy_mode = 1;
        for (int i = 0; i < 3 * W * H; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            send_rand();
        end
        drain();
        rdy_mode = 0;
        @(posedge clk); #1;

        // Reset mid-frame after 6 accepted pairs
        for (int i = 0; i < 6; i++) send_rand();
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check_eq("midrst_valid", out_valid, 0);
        check_eq("midrst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        mark = log_pix.size();
        for (int i = 0; i < W * H; i++) send(60, 60, 0, 0);
        drain();
        check_eq("post_rst_sof", log_sof[mark], 1);
        check_eq("post_rst_border", log_pix[mark], 0);
        check_eq("post_rst_int", log_pix[mark + 5], 120);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
